regfile_wb_scheduler: RTL and testbench

- Owns the register file's single write port and shares it between two writeback sources.
  - In-order pipeline writeback: ALU/load path, fixed priority, no backpressure.
  - Multi-cycle MUL/DIV unit (MDU): valid/ready, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding MDU destinations and raises a decode stall on RAW/WAW hazards.
- Sits between the decode/writeback stages and the register file.

---
 rtl/regfile_wb_scheduler_pkg.sv | 25 ++
 rtl/regfile_wb_scheduler_if.sv | 62 ++++++
 rtl/regfile_wb_fifo.sv | 56 +++++
 rtl/regfile_wb_scheduler.sv | 125 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, writeback entry layout and write-port source encoding for the
// register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

   localparam int                   REG_IDX_W = 5;
   localparam int                   XLEN      = 32;
   localparam logic [REG_IDX_W-1:0] ZERO_REG  = '0;
   localparam int                   ENTRY_W   = REG_IDX_W + XLEN;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_PIPE = 2'd1,
      WB_FIFO = 2'd2
   } wb_src_e;

   function automatic logic [31:0] onehot_reg(input logic [REG_IDX_W-1:0] idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Decode, writeback and register-file signals of the writeback scheduler,
// plus debug taps exposing the busy scoreboard and the current write-port source.
interface regfile_wb_scheduler_if
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int MDU_FIFO_DEPTH = 2
) ();

   localparam int PEND_W = $clog2(MDU_FIFO_DEPTH) + 1;

   logic                 issue_valid;
   logic                 issue_is_mdu;
   logic [REG_IDX_W-1:0] dec_rs1;
   logic [REG_IDX_W-1:0] dec_rs2;
   logic [REG_IDX_W-1:0] dec_rd;
   logic                 dec_use_rs1;
   logic                 dec_use_rs2;
   logic                 dec_use_rd;
   logic                 dec_stall;

   logic                 pipe_wb_valid;
   logic [REG_IDX_W-1:0] pipe_wb_rd;
   logic [XLEN-1:0]      pipe_wb_data;
   logic                 pipe_hold;

   // MDU handshake: a result transfers at a posedge where mdu_wb_valid and
   // mdu_wb_ready are both 1; the source holds rd/data stable until then.
   logic                 mdu_wb_valid;
   logic [REG_IDX_W-1:0] mdu_wb_rd;
   logic [XLEN-1:0]      mdu_wb_data;
   logic                 mdu_wb_ready;
   logic [PEND_W-1:0]    mdu_pending;

   logic                 rf_write_enable;
   logic [REG_IDX_W-1:0] rf_rd;
   logic [XLEN-1:0]      rf_rd_din;
   logic                 err_sticky;

   logic [31:0]          dbg_busy;
   wb_src_e              dbg_src;

   modport slave (
      input  issue_valid, issue_is_mdu, dec_rs1, dec_rs2, dec_rd,
             dec_use_rs1, dec_use_rs2, dec_use_rd,
             pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
             mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
      output dec_stall, pipe_hold, mdu_wb_ready, mdu_pending,
             rf_write_enable, rf_rd, rf_rd_din, err_sticky,
             dbg_busy, dbg_src
   );

   modport master (
      output issue_valid, issue_is_mdu, dec_rs1, dec_rs2, dec_rd,
             dec_use_rs1, dec_use_rs2, dec_use_rd,
             pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
             mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
      input  dec_stall, pipe_hold, mdu_wb_ready, mdu_pending,
             rf_write_enable, rf_rd, rf_rd_din, err_sticky,
             dbg_busy, dbg_src
   );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO buffering MDU results; full/empty/count come from registered
// state only, so a pop never frees a slot for a push in the same cycle.
module regfile_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_din,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register file's single write port between the in-order pipe
// and buffered MDU results, tracks outstanding MDU destinations and stalls decode.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int MDU_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_wb_scheduler_if.slave  bus
);

   localparam int                PEND_W      = $clog2(MDU_FIFO_DEPTH) + 1;
   localparam int                CNT_W       = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam logic [CNT_W-1:0]  STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);

   logic [31:0]        r_busy;
   logic [CNT_W-1:0]   r_starve_cnt;
   logic               r_pipe_hold;
   logic               r_err_sticky;

   logic [ENTRY_W-1:0] w_head_raw;
   wb_entry_t          w_head;
   wb_entry_t          w_mdu_entry;
   wb_entry_t          w_winner;
   wb_src_e            w_src;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic [PEND_W-1:0]  w_count;
   logic               w_dec_stall;
   logic               w_issue_set;
   logic [31:0]        w_set_mask;
   logic [31:0]        w_clr_mask;
   logic               w_starve_inc;
   logic               w_err_event;

   assign w_mdu_entry = '{rd: bus.mdu_wb_rd, data: bus.mdu_wb_data};
   assign w_push      = bus.mdu_wb_valid & ~w_full;
   assign w_head      = wb_entry_t'(w_head_raw);

   regfile_wb_fifo #(
      .DEPTH (MDU_FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_din   (w_mdu_entry),
      .i_pop   (w_pop),
      .o_dout  (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Pipe has absolute priority; an rd==0 winner is still consumed.
   always_comb begin
      w_src    = WB_IDLE;
      w_winner = '0;
      if (bus.pipe_wb_valid) begin
         w_src    = WB_PIPE;
         w_winner = '{rd: bus.pipe_wb_rd, data: bus.pipe_wb_data};
      end else if (!w_empty) begin
         w_src    = WB_FIFO;
         w_winner = w_head;
      end
   end

   assign w_pop = (w_src == WB_FIFO);

   assign w_dec_stall = (bus.dec_use_rs1 & r_busy[bus.dec_rs1])
                      | (bus.dec_use_rs2 & r_busy[bus.dec_rs2])
                      | (bus.dec_use_rd  & r_busy[bus.dec_rd]);

   assign w_issue_set = bus.issue_valid & ~w_dec_stall & bus.issue_is_mdu
                      & (bus.dec_rd != ZERO_REG);
   assign w_set_mask  = w_issue_set ? onehot_reg(bus.dec_rd) : 32'd0;
   assign w_clr_mask  = w_pop ? onehot_reg(w_head.rd) : 32'd0;

   assign w_starve_inc = bus.pipe_wb_valid & ~w_empty;

   assign w_err_event = (bus.pipe_wb_valid & r_pipe_hold)
                      | (bus.mdu_wb_valid & (bus.mdu_wb_rd != ZERO_REG) & ~r_busy[bus.mdu_wb_rd])
                      | (bus.mdu_wb_valid & w_full);

   // Set is OR-ed after clear so a same-register set/clear leaves it busy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy       <= '0;
         r_starve_cnt <= '0;
         r_pipe_hold  <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
         if (w_starve_inc) begin
            if (r_starve_cnt == STARVE_LAST) begin
               r_starve_cnt <= '0;
               r_pipe_hold  <= 1'b1;
            end else begin
               r_starve_cnt <= r_starve_cnt + CNT_W'(1);
               r_pipe_hold  <= 1'b0;
            end
         end else begin
            r_starve_cnt <= '0;
            r_pipe_hold  <= 1'b0;
         end
         if (w_err_event) r_err_sticky <= 1'b1;
      end
   end

   assign bus.dec_stall       = w_dec_stall;
   assign bus.pipe_hold       = r_pipe_hold;
   assign bus.mdu_wb_ready    = ~w_full;
   assign bus.mdu_pending     = w_count;
   assign bus.rf_write_enable = (w_src != WB_IDLE) & (w_winner.rd != ZERO_REG);
   assign bus.rf_rd           = w_winner.rd;
   assign bus.rf_rd_din       = w_winner.data;
   assign bus.err_sticky      = r_err_sticky;
   assign bus.dbg_busy        = r_busy;
   assign bus.dbg_src         = w_src;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: inputs change 1 time unit after
// posedge, outputs are checked on the following negedge.
module tb_regfile_wb_scheduler;
   import regfile_wb_scheduler_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   regfile_wb_scheduler_if #(.MDU_FIFO_DEPTH(2)) bus ();

   regfile_wb_scheduler #(
      .MDU_FIFO_DEPTH (2),
      .STARVE_LIMIT   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid   = 1'b0;
      bus.issue_is_mdu  = 1'b0;
      bus.dec_rs1       = '0;
      bus.dec_rs2       = '0;
      bus.dec_rd        = '0;
      bus.dec_use_rs1   = 1'b0;
      bus.dec_use_rs2   = 1'b0;
      bus.dec_use_rd    = 1'b0;
      bus.pipe_wb_valid = 1'b0;
      bus.pipe_wb_rd    = '0;
      bus.pipe_wb_data  = '0;
      bus.mdu_wb_valid  = 1'b0;
      bus.mdu_wb_rd     = '0;
      bus.mdu_wb_data   = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   task automatic issue_mdu(input logic [4:0] rd);
      bus.issue_valid  = 1'b1;
      bus.issue_is_mdu = 1'b1;
      bus.dec_rd       = rd;
      bus.dec_use_rd   = 1'b1;
      cyc();
      bus.issue_valid  = 1'b0;
      bus.issue_is_mdu = 1'b0;
      bus.dec_use_rd   = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      @(negedge clk);
      n_total++; if (bus.dbg_busy !== 32'd0) $display("FAIL reset_busy: got %h want 0", bus.dbg_busy); else n_pass++;
      n_total++; if (bus.rf_write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.rf_write_enable); else n_pass++;
      n_total++; if (bus.mdu_wb_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.mdu_wb_ready); else n_pass++;
      n_total++; if (bus.mdu_pending !== 2'd0) $display("FAIL reset_pending: got %0d want 0", bus.mdu_pending); else n_pass++;
      n_total++; if (bus.pipe_hold !== 1'b0) $display("FAIL reset_hold: got %b want 0", bus.pipe_hold); else n_pass++;
      n_total++; if (bus.err_sticky !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_sticky); else n_pass++;
      cyc();
   endtask

   task automatic test_mdu_raw();
      bus.issue_valid  = 1'b1;
      bus.issue_is_mdu = 1'b1;
      bus.dec_rd       = 5'd5;
      bus.dec_use_rd   = 1'b1;
      @(negedge clk);
      n_total++; if (bus.dec_stall !== 1'b0) $display("FAIL raw_issue_stall: got %b want 0", bus.dec_stall); else n_pass++;
      cyc();
      idle();
      bus.dec_rs1      = 5'd5;
      bus.dec_use_rs1  = 1'b1;
      bus.mdu_wb_valid = 1'b1;
      bus.mdu_wb_rd    = 5'd5;
      bus.mdu_wb_data  = 32'hDEADBEEF;
      @(negedge clk);
      n_total++; if (bus.dbg_busy !== 32'h0000_0020) $display("FAIL raw_busy: got %h want 00000020", bus.dbg_busy); else n_pass++;
      n_total++; if (bus.dec_stall !== 1'b1) $display("FAIL raw_stall_n: got %b want 1", bus.dec_stall); else n_pass++;
      n_total++; if (bus.rf_write_enable !== 1'b0) $display("FAIL raw_we_n: got %b want 0", bus.rf_write_enable); else n_pass++;
      cyc();
      bus.mdu_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.rf_write_enable !== 1'b1) $display("FAIL raw_we_n1: got %b want 1", bus.rf_write_enable); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd5) $display("FAIL raw_rd_n1: got %0d want 5", bus.rf_rd); else n_pass++;
      n_total++; if (bus.rf_rd_din !== 32'hDEADBEEF) $display("FAIL raw_din_n1: got %h want deadbeef", bus.rf_rd_din); else n_pass++;
      n_total++; if (bus.dec_stall !== 1'b1) $display("FAIL raw_stall_n1: got %b want 1", bus.dec_stall); else n_pass++;
      cyc();
      @(negedge clk);
      n_total++; if (bus.dec_stall !== 1'b0) $display("FAIL raw_stall_n2: got %b want 0", bus.dec_stall); else n_pass++;
      n_total++; if (bus.mdu_pending !== 2'd0) $display("FAIL raw_pending_n2: got %0d want 0", bus.mdu_pending); else n_pass++;
      n_total++; if (bus.err_sticky !== 1'b0) $display("FAIL raw_err: got %b want 0", bus.err_sticky); else n_pass++;
      cyc();
      idle();
   endtask

   task automatic test_starve();
      issue_mdu(5'd8);
      issue_mdu(5'd9);
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd3;
      bus.pipe_wb_data  = 32'h11;
      bus.mdu_wb_valid  = 1'b1;
      bus.mdu_wb_rd     = 5'd8;
      bus.mdu_wb_data   = 32'hA8;
      @(negedge clk);
      n_total++; if (bus.rf_rd !== 5'd3 || bus.rf_write_enable !== 1'b1) $display("FAIL starve_p1: got we=%b rd=%0d want we=1 rd=3", bus.rf_write_enable, bus.rf_rd); else n_pass++;
      cyc();
      bus.mdu_wb_rd   = 5'd9;
      bus.mdu_wb_data = 32'hA9;
      cyc();
      bus.mdu_wb_valid = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      n_total++; if (bus.pipe_hold !== 1'b0) $display("FAIL starve_hold_p5: got %b want 0", bus.pipe_hold); else n_pass++;
      n_total++; if (bus.mdu_pending !== 2'd2) $display("FAIL starve_pending_p5: got %0d want 2", bus.mdu_pending); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd3 || bus.rf_rd_din !== 32'h11) $display("FAIL starve_pipe_p5: got rd=%0d din=%h want rd=3 din=11", bus.rf_rd, bus.rf_rd_din); else n_pass++;
      cyc();
      bus.pipe_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.pipe_hold !== 1'b1) $display("FAIL starve_hold_p6: got %b want 1", bus.pipe_hold); else n_pass++;
      n_total++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd !== 5'd8) $display("FAIL starve_head0: got we=%b rd=%0d want we=1 rd=8", bus.rf_write_enable, bus.rf_rd); else n_pass++;
      n_total++; if (bus.rf_rd_din !== 32'hA8) $display("FAIL starve_din0: got %h want a8", bus.rf_rd_din); else n_pass++;
      cyc();
      @(negedge clk);
      n_total++; if (bus.pipe_hold !== 1'b0) $display("FAIL starve_hold_p7: got %b want 0", bus.pipe_hold); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd9 || bus.rf_rd_din !== 32'hA9) $display("FAIL starve_head1: got rd=%0d din=%h want rd=9 din=a9", bus.rf_rd, bus.rf_rd_din); else n_pass++;
      cyc();
      @(negedge clk);
      n_total++; if (bus.mdu_pending !== 2'd0 || bus.rf_write_enable !== 1'b0) $display("FAIL starve_drained: got pending=%0d we=%b want 0 0", bus.mdu_pending, bus.rf_write_enable); else n_pass++;
      n_total++; if (bus.dbg_busy !== 32'd0 || bus.err_sticky !== 1'b0) $display("FAIL starve_clean: got busy=%h err=%b want 0 0", bus.dbg_busy, bus.err_sticky); else n_pass++;
      cyc();
      idle();
   endtask

   task automatic test_fifo_full();
      issue_mdu(5'd10);
      issue_mdu(5'd11);
      issue_mdu(5'd12);
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd3;
      bus.pipe_wb_data  = 32'h22;
      bus.mdu_wb_valid  = 1'b1;
      bus.mdu_wb_rd     = 5'd10;
      bus.mdu_wb_data   = 32'hB0;
      cyc();
      bus.mdu_wb_rd   = 5'd11;
      bus.mdu_wb_data = 32'hB1;
      cyc();
      bus.mdu_wb_rd   = 5'd12;
      bus.mdu_wb_data = 32'hB2;
      @(negedge clk);
      n_total++; if (bus.mdu_wb_ready !== 1'b0) $display("FAIL full_ready_q3: got %b want 0", bus.mdu_wb_ready); else n_pass++;
      n_total++; if (bus.mdu_pending !== 2'd2) $display("FAIL full_pending_q3: got %0d want 2", bus.mdu_pending); else n_pass++;
      cyc();
      bus.pipe_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.mdu_wb_ready !== 1'b0) $display("FAIL full_ready_q4: got %b want 0", bus.mdu_wb_ready); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd10 || bus.rf_rd_din !== 32'hB0) $display("FAIL full_head0: got rd=%0d din=%h want rd=10 din=b0", bus.rf_rd, bus.rf_rd_din); else n_pass++;
      cyc();
      @(negedge clk);
      n_total++; if (bus.mdu_wb_ready !== 1'b1) $display("FAIL full_ready_q5: got %b want 1", bus.mdu_wb_ready); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd11 || bus.mdu_pending !== 2'd1) $display("FAIL full_head1: got rd=%0d pending=%0d want rd=11 pending=1", bus.rf_rd, bus.mdu_pending); else n_pass++;
      cyc();
      bus.mdu_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.rf_rd !== 5'd12 || bus.rf_rd_din !== 32'hB2) $display("FAIL full_head2: got rd=%0d din=%h want rd=12 din=b2", bus.rf_rd, bus.rf_rd_din); else n_pass++;
      n_total++; if (bus.mdu_pending !== 2'd1) $display("FAIL full_pending_q6: got %0d want 1", bus.mdu_pending); else n_pass++;
      cyc();
      @(negedge clk);
      n_total++; if (bus.mdu_pending !== 2'd0) $display("FAIL full_pending_q7: got %0d want 0", bus.mdu_pending); else n_pass++;
      n_total++; if (bus.err_sticky !== 1'b1) $display("FAIL full_err: got %b want 1", bus.err_sticky); else n_pass++;
      cyc();
      do_reset();
      @(negedge clk);
      n_total++; if (bus.err_sticky !== 1'b0) $display("FAIL full_err_cleared: got %b want 0", bus.err_sticky); else n_pass++;
      cyc();
   endtask

   task automatic test_rd_zero();
      bus.mdu_wb_valid = 1'b1;
      bus.mdu_wb_rd    = 5'd0;
      bus.mdu_wb_data  = 32'h55;
      cyc();
      bus.mdu_wb_valid  = 1'b0;
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd0;
      bus.pipe_wb_data  = 32'h77;
      @(negedge clk);
      n_total++; if (bus.rf_write_enable !== 1'b0) $display("FAIL zero_pipe_we: got %b want 0", bus.rf_write_enable); else n_pass++;
      n_total++; if (bus.mdu_pending !== 2'd1) $display("FAIL zero_pending_r2: got %0d want 1", bus.mdu_pending); else n_pass++;
      cyc();
      bus.pipe_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.rf_write_enable !== 1'b0) $display("FAIL zero_fifo_we: got %b want 0", bus.rf_write_enable); else n_pass++;
      n_total++; if (bus.dbg_src !== WB_FIFO) $display("FAIL zero_src: got %0d want %0d", bus.dbg_src, WB_FIFO); else n_pass++;
      cyc();
      @(negedge clk);
      n_total++; if (bus.mdu_pending !== 2'd0) $display("FAIL zero_popped: got %0d want 0", bus.mdu_pending); else n_pass++;
      n_total++; if (bus.err_sticky !== 1'b0) $display("FAIL zero_err: got %b want 0", bus.err_sticky); else n_pass++;
      cyc();
      idle();
   endtask

   task automatic test_err();
      bus.mdu_wb_valid = 1'b1;
      bus.mdu_wb_rd    = 5'd7;
      bus.mdu_wb_data  = 32'h7777;
      cyc();
      bus.mdu_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.err_sticky !== 1'b1) $display("FAIL err_notbusy: got %b want 1", bus.err_sticky); else n_pass++;
      n_total++; if (bus.rf_write_enable !== 1'b1 || bus.rf_rd !== 5'd7) $display("FAIL err_notbusy_wr: got we=%b rd=%0d want we=1 rd=7", bus.rf_write_enable, bus.rf_rd); else n_pass++;
      cyc();
      cyc();
      @(negedge clk);
      n_total++; if (bus.err_sticky !== 1'b1) $display("FAIL err_sticky_hold: got %b want 1", bus.err_sticky); else n_pass++;
      cyc();
      do_reset();
      @(negedge clk);
      n_total++; if (bus.err_sticky !== 1'b0) $display("FAIL err_reset1: got %b want 0", bus.err_sticky); else n_pass++;
      cyc();
      issue_mdu(5'd13);
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd3;
      bus.pipe_wb_data  = 32'h33;
      bus.mdu_wb_valid  = 1'b1;
      bus.mdu_wb_rd     = 5'd13;
      bus.mdu_wb_data   = 32'hD;
      cyc();
      bus.mdu_wb_valid = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      @(negedge clk);
      n_total++; if (bus.pipe_hold !== 1'b1) $display("FAIL err_hold_h6: got %b want 1", bus.pipe_hold); else n_pass++;
      n_total++; if (bus.err_sticky !== 1'b0) $display("FAIL err_before_viol: got %b want 0", bus.err_sticky); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd3 || bus.rf_rd_din !== 32'h33) $display("FAIL err_pipe_wins: got rd=%0d din=%h want rd=3 din=33", bus.rf_rd, bus.rf_rd_din); else n_pass++;
      cyc();
      bus.pipe_wb_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.err_sticky !== 1'b1) $display("FAIL err_hold_viol: got %b want 1", bus.err_sticky); else n_pass++;
      n_total++; if (bus.rf_rd !== 5'd13 || bus.rf_rd_din !== 32'hD) $display("FAIL err_drain: got rd=%0d din=%h want rd=13 din=d", bus.rf_rd, bus.rf_rd_din); else n_pass++;
      cyc();
      do_reset();
      @(negedge clk);
      n_total++; if (bus.err_sticky !== 1'b0 || bus.dbg_busy !== 32'd0) $display("FAIL err_reset2: got err=%b busy=%h want 0 0", bus.err_sticky, bus.dbg_busy); else n_pass++;
      cyc();
   endtask

   initial begin
      idle();
      test_reset();
      test_mdu_raw();
      test_starve();
      test_fifo_full();
      test_rd_zero();
      test_err();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
